vc_scheduler: RTL and testbench
===============================

VC_SCHEDULER -- requirements
Module: vc_scheduler

Interface
REQ-001 Parameter: WORD_SIZE, 6, width of a packet word.
REQ-002 Parameter: WEIGHT_W, 4, width of the per-VC weight and the credit counter.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, named as follows.
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous, active-low reset.
REQ-004 The block SHALL have these remaining ports.
- enable  in  1  scheduling allowed (driven from the state machine's active_out).
- weight_vc0  in  WEIGHT_W  VC0 grant burst length; 0 treated as 1.
- weight_vc1  in  WEIGHT_W  VC1 grant burst length; 0 treated as 1.
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_data  in  WORD_SIZE  VC0 FIFO read data, valid the cycle after pop.
- vc1_data  in  WORD_SIZE  VC1 FIFO read data, valid the cycle after pop.
- pause_d0  in  1  D0 FIFO almost-full.
- pause_d1  in  1  D1 FIFO almost-full.
- pop_vc0  out  1  VC0 FIFO read strobe.
- pop_vc1  out  1  VC1 FIFO read strobe.
- data_out  out  WORD_SIZE  word forwarded to the destination FIFOs.
- push_d0  out  1  write strobe for D0.
- push_d1  out  1  write strobe for D1.
- grant_vc  out  1  VC currently owning the grant (0/1).
- idle_out  out  1  no grant held and nothing in flight.

Function
REQ-005 The block SHALL compute elig0 = enable & ~vc0_empty & ~pause_d0 & ~pause_d1; elig1 is defined the same way for VC1.
REQ-006 The block SHALL implement FSM states IDLE, SERVE0 and SERVE1, plus a credit counter of WEIGHT_W bits.
REQ-007 IDLE transitions:
- elig0 -> SERVE0, credit = max(weight_vc0, 1).
- else elig1 -> SERVE1, credit = max(weight_vc1, 1).
- else remain in IDLE.
REQ-008 pop_vc0 SHALL be combinational and equal (state==SERVE0) & elig0; pop_vc1 is defined the same way for SERVE1; the two SHALL never be high together.
REQ-009 Each pop SHALL decrement credit by 1.
REQ-010 SERVE0, on a pop with credit==1:
- elig1 -> SERVE1, load weight_vc1.
- else ~vc0_empty -> stay in SERVE0, reload weight_vc0.
- else -> IDLE.
REQ-011 SERVE0 with vc0_empty and enable high:
- elig1 -> SERVE1, load weight_vc1.
- !elig1 & vc1_empty -> IDLE.
REQ-012 In SERVE0, while pause_d0 or pause_d1 is high and VC0 is not empty, the FSM SHALL hold state and credit with no pop.
REQ-013 SERVE1 SHALL mirror REQ-010 to REQ-012 with VC0 and VC1 swapped.
REQ-014 enable low in SERVEx SHALL move the FSM to IDLE on the next edge; a pop already issued SHALL still complete.
REQ-015 Output stage, in the cycle after a pop:
- data_out <= vcX_data of the popped VC.
- push_d0 <= ~vcX_data[4].
- push_d1 <= vcX_data[4].
- 1-cycle pop-to-push latency.
REQ-016 Without a pop in the previous cycle, push_d0 and push_d1 SHALL be 0, and data_out SHALL hold its last value.
REQ-017 Weight inputs SHALL be sampled only at credit load; changes during a burst SHALL not affect the current burst.
REQ-018 grant_vc SHALL be 1 only in SERVE1 and SHALL otherwise hold its last value.
REQ-019 idle_out SHALL equal (state==IDLE) & ~push_d0 & ~push_d1.
REQ-020 Sustained throughput SHALL be one word per cycle with no bubble on grant switch.

Reset
REQ-021 While reset_L is low, the block SHALL asynchronously force:
- state = IDLE, credit = 0.
- data_out = 0, push_d0 = 0, push_d1 = 0, grant_vc = 0.
- pop_vc0 = 0, pop_vc1 = 0 (state-gated).
- idle_out = 1.
REQ-022 Reset asserted mid-burst SHALL discard the in-flight word: no push on the first edge after release.

Structure
REQ-023 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2) and the destination bit index DEST_BIT=4.
REQ-024 The block SHALL contain one sub-module, vc_credit_counter: load, decrement and expired flag.
REQ-025 The top level instantiates vc_scheduler in place of the existing empty/pause pop logic, mux and destination demux path.

Verification
REQ-026 The bench SHALL cover these directed scenarios.
- weights 3/1, both VCs preloaded with 8 words, no pause -> pop order 0,0,0,1,0,0,0,1,...; pushes one cycle later.
- weight_vc0=0, weight_vc1=2 -> VC0 gets single-word bursts: 0,1,1,0,1,1.
- VC1 empty, VC0 has 5 words, weight_vc0=2 -> five consecutive pops of VC0, then IDLE with idle_out=1 two cycles after the last pop.
- pause_d1 raised for 4 cycles mid-burst -> no pops during the pause, credit preserved, burst resumes with the remaining count.
- vc0_data=6'b010101 popped -> push_d1=1, push_d0=0, data_out=6'h15; vc0_data=6'b000011 -> push_d0=1.
- reset_L pulsed low the cycle after a pop -> outputs 0 immediately; no push after release; FSM in IDLE.

Source files
------------

// File: rtl/vc_scheduler_pkg.sv
// Shared constants for the two-VC weighted scheduler.
// FSM encoding and the destination-select bit of a packet word.
package vc_scheduler_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERVE0 = 2'd1;
  localparam logic [1:0] SERVE1 = 2'd2;

  localparam int DEST_BIT = 4;

endpackage

// File: rtl/vc_credit_counter.sv
// Burst credit counter: load, decrement, and a flag for the last credit.
// Load wins over decrement so a reload on the last pop starts a fresh burst.
module vc_credit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/vc_scheduler.sv
// Weighted round-robin scheduler between two VC FIFOs, forwarding
// each popped word to D0 or D1 one cycle later by its destination bit.
module vc_scheduler
  import vc_scheduler_pkg::*;
#(
  parameter int WORD_SIZE = 6,
  parameter int WEIGHT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  input  logic [WEIGHT_W-1:0]  weight_vc0,
  input  logic [WEIGHT_W-1:0]  weight_vc1,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [WORD_SIZE-1:0] vc0_data,
  input  logic [WORD_SIZE-1:0] vc1_data,
  input  logic                 pause_d0,
  input  logic                 pause_d1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic                 grant_vc,
  output logic                 idle_out
);

  localparam logic [WEIGHT_W-1:0] ONE = WEIGHT_W'(1);

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic                 elig0;
  logic                 elig1;
  logic                 pause;
  logic [WEIGHT_W-1:0]  w0;
  logic [WEIGHT_W-1:0]  w1;
  logic                 load;
  logic                 dec;
  logic [WEIGHT_W-1:0]  load_val;
  logic                 expired;
  logic                 pop_any;
  logic [WORD_SIZE-1:0] pop_word;

  assign pause = pause_d0 | pause_d1;
  assign elig0 = enable & ~vc0_empty & ~pause;
  assign elig1 = enable & ~vc1_empty & ~pause;

  assign w0 = (weight_vc0 == '0) ? ONE : weight_vc0;
  assign w1 = (weight_vc1 == '0) ? ONE : weight_vc1;

  assign pop_vc0 = (state == SERVE0) & elig0;
  assign pop_vc1 = (state == SERVE1) & elig1;
  assign pop_any = pop_vc0 | pop_vc1;
  assign pop_word = pop_vc1 ? vc1_data : vc0_data;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = w0;
    dec      = 1'b0;
    unique case (1'b1)
      state == SERVE0: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (pop_vc0) begin
          if (!expired) begin
            dec = 1'b1;
          end else if (elig1) begin
            state_nx = SERVE1;
            load     = 1'b1;
            load_val = w1;
          end else begin
            load     = 1'b1;
            load_val = w0;
          end
        end else if (vc0_empty) begin
          if (elig1) begin
            state_nx = SERVE1;
            load     = 1'b1;
            load_val = w1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      state == SERVE1: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (pop_vc1) begin
          if (!expired) begin
            dec = 1'b1;
          end else if (elig0) begin
            state_nx = SERVE0;
            load     = 1'b1;
            load_val = w0;
          end else begin
            load     = 1'b1;
            load_val = w1;
          end
        end else if (vc1_empty) begin
          if (elig0) begin
            state_nx = SERVE0;
            load     = 1'b1;
            load_val = w0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        if (elig0) begin
          state_nx = SERVE0;
          load     = 1'b1;
          load_val = w0;
        end else if (elig1) begin
          state_nx = SERVE1;
          load     = 1'b1;
          load_val = w1;
        end else begin
          state_nx = IDLE;
        end
      end
    endcase
  end

  vc_credit_counter #(
    .W (WEIGHT_W)
  ) u_credit (
    .clk      (clk),
    .reset_L  (reset_L),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // grant follows the served VC and is left untouched while idle
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      grant_vc <= 1'b0;
    end else if (state_nx == SERVE1) begin
      grant_vc <= 1'b1;
    end else if (state_nx == SERVE0) begin
      grant_vc <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
      push_d0  <= 1'b0;
      push_d1  <= 1'b0;
    end else begin
      push_d0 <= pop_any & ~pop_word[DEST_BIT];
      push_d1 <= pop_any & pop_word[DEST_BIT];
      if (pop_any) begin
        data_out <= pop_word;
      end
    end
  end

  assign idle_out = (state == IDLE) & ~push_d0 & ~push_d1;

endmodule

// File: tb/tb_vc_scheduler.sv
// Directed bench for vc_scheduler: a vector table for single-cycle
// behaviour plus FIFO-model sequences for burst and pause scenarios.
module tb_vc_scheduler;

  localparam int WS = 6;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          enable = 1'b0;
  logic [WW-1:0] weight_vc0 = '0;
  logic [WW-1:0] weight_vc1 = '0;
  logic          vc0_empty = 1'b1;
  logic          vc1_empty = 1'b1;
  logic [WS-1:0] vc0_data = '0;
  logic [WS-1:0] vc1_data = '0;
  logic          pause_d0 = 1'b0;
  logic          pause_d1 = 1'b0;
  logic          pop_vc0;
  logic          pop_vc1;
  logic [WS-1:0] data_out;
  logic          push_d0;
  logic          push_d1;
  logic          grant_vc;
  logic          idle_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vc_scheduler #(
    .WORD_SIZE (WS),
    .WEIGHT_W  (WW)
  ) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .enable     (enable),
    .weight_vc0 (weight_vc0),
    .weight_vc1 (weight_vc1),
    .vc0_empty  (vc0_empty),
    .vc1_empty  (vc1_empty),
    .vc0_data   (vc0_data),
    .vc1_data   (vc1_data),
    .pause_d0   (pause_d0),
    .pause_d1   (pause_d1),
    .pop_vc0    (pop_vc0),
    .pop_vc1    (pop_vc1),
    .data_out   (data_out),
    .push_d0    (push_d0),
    .push_d1    (push_d1),
    .grant_vc   (grant_vc),
    .idle_out   (idle_out)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          rst_l;
    logic          en;
    logic          e0;
    logic          e1;
    logic          pz0;
    logic          pz1;
    logic [WS-1:0] d0;
    logic [WS-1:0] d1;
    logic          xp0;
    logic          xp1;
    logic          xq0;
    logic          xq1;
    logic [WS-1:0] xd;
    logic          xg;
    logic          xi;
  } vec_t;

  vec_t tbl[15];

  function automatic logic [WS-1:0] word0(input int k);
    return WS'((k * 9 + 5) & 63);
  endfunction

  function automatic logic [WS-1:0] word1(input int k);
    return WS'((k * 13 + 2) & 63);
  endfunction

  task automatic run_seq(input string name,
                         input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                         input int n0, input int n1,
                         input int pst, input int plen,
                         input string exp_pop, input string exp_idle);
    int c0;
    int c1;
    int k0;
    int k1;
    int idx;
    int len;
    logic started;
    logic prev;
    logic [WS-1:0] prev_w;
    logic [WS-1:0] last_d;
    logic p0;
    logic p1;
    string got;
    string idl;
    c0 = n0;
    c1 = n1;
    k0 = 0;
    k1 = 0;
    idx = 0;
    len = exp_pop.len();
    started = 1'b0;
    prev = 1'b0;
    prev_w = '0;
    last_d = '0;
    got = "";
    idl = "";
    @(posedge clk);
    #1;
    reset_L = 1'b0;
    enable = 1'b1;
    weight_vc0 = w0;
    weight_vc1 = w1;
    pause_d0 = 1'b0;
    pause_d1 = 1'b0;
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    for (int c = 0; c < 80 && idx < len; c++) begin
      pause_d1 = started && idx >= pst && idx < pst + plen;
      vc0_empty = (c0 == 0);
      vc1_empty = (c1 == 0);
      vc0_data = word0(k0);
      vc1_data = word1(k1);
      @(negedge clk);
      check({name, "/push_d0"}, push_d0, prev & ~prev_w[4]);
      check({name, "/push_d1"}, push_d1, prev & prev_w[4]);
      if (prev) last_d = prev_w;
      check({name, "/data_out"}, data_out, last_d);
      p0 = pop_vc0;
      p1 = pop_vc1;
      if (p0 & p1) check({name, "/pop_excl"}, 2, 1);
      if (p0 | p1) started = 1'b1;
      if (started) begin
        got = {got, p0 ? "0" : (p1 ? "1" : "-")};
        idl = {idl, idle_out ? "I" : "."};
        idx++;
      end
      prev = p0 | p1;
      prev_w = p1 ? word1(k1) : word0(k0);
      @(posedge clk);
      #1;
      if (p0) begin c0--; k0++; end
      if (p1) begin c1--; k1++; end
    end
    check({name, "/cycles"}, idx, len);
    checks++;
    if (got != exp_pop) begin
      errors++;
      $display("FAIL %s/pop_order: got %s expected %s", name, got, exp_pop);
    end
    if (exp_idle.len() > 0) begin
      checks++;
      if (idl != exp_idle) begin
        errors++;
        $display("FAIL %s/idle: got %s expected %s", name, idl, exp_idle);
      end
    end
    pause_d1 = 1'b0;
  endtask

  initial begin
    // rst en e0 e1 pz0 pz1 d0 d1 | pop0 pop1 push0 push1 data grant idle
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 6'h00,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15, 6'h00,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h15, 6'h00,
                1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h03, 6'h00,
                1'b1, 1'b0, 1'b0, 1'b1, 6'h15, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h03, 6'h00,
                1'b0, 1'b0, 1'b1, 1'b0, 6'h03, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h2a,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h2a,
                1'b0, 1'b1, 1'b0, 1'b0, 6'h03, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h10,
                1'b0, 1'b0, 1'b1, 1'b0, 6'h2a, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 6'h10,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h2a, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'h15, 6'h10,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h2a, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 6'h10,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h2a, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 6'h10,
                1'b1, 1'b0, 1'b0, 1'b0, 6'h2a, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 6'h10,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 6'h10,
                1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h15, 6'h10,
                1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0};

    weight_vc0 = 4'd3;
    weight_vc1 = 4'd1;
    for (int i = 0; i < 15; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(posedge clk);
      #1;
      reset_L   = tbl[i].rst_l;
      enable    = tbl[i].en;
      vc0_empty = tbl[i].e0;
      vc1_empty = tbl[i].e1;
      pause_d0  = tbl[i].pz0;
      pause_d1  = tbl[i].pz1;
      vc0_data  = tbl[i].d0;
      vc1_data  = tbl[i].d1;
      @(negedge clk);
      check({tag, "/pop_vc0"}, pop_vc0, tbl[i].xp0);
      check({tag, "/pop_vc1"}, pop_vc1, tbl[i].xp1);
      check({tag, "/push_d0"}, push_d0, tbl[i].xq0);
      check({tag, "/push_d1"}, push_d1, tbl[i].xq1);
      check({tag, "/data_out"}, data_out, tbl[i].xd);
      check({tag, "/grant_vc"}, grant_vc, tbl[i].xg);
      check({tag, "/idle_out"}, idle_out, tbl[i].xi);
    end

    run_seq("w3_1", 4'd3, 4'd1, 8, 8, 99, 0,
            "0001000100-111111", "");
    run_seq("w0_2", 4'd0, 4'd2, 4, 4, 99, 0, "011011", "");
    run_seq("drain", 4'd2, 4'd1, 5, 0, 99, 0, "00000--", "......I");
    run_seq("pause", 4'd4, 4'd1, 8, 8, 2, 4, "00----001", "");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
